// File: rtl/store_buffer_if.sv
// Store-buffer bus: MEM-stage store/load requests in, memory write port and
// back-pressure out. The parameter must match the DEPTH of the attached buffer.
interface store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [1:0]       memwriteM;
    logic [31:0]      aluoutM;
    logic [31:0]      writedataM;
    logic             memreadM;
    logic [31:0]      loadadrM;
    logic             mem_ready;
    logic             stall;
    logic             hazard;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic [CNT_W-1:0] count;

    modport master (
        output memwriteM, aluoutM, writedataM, memreadM, loadadrM, mem_ready,
        input  stall, hazard, mem_we, mem_addr, mem_wdata, mem_be, count
    );

    modport slave (
        input  memwriteM, aluoutM, writedataM, memreadM, loadadrM, mem_ready,
        output stall, hazard, mem_we, mem_addr, mem_wdata, mem_be, count
    );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: queues MEM-stage stores in a circular FIFO, drains the
// head to data memory and flags loads that overlap a pending store word.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Entry payload is not reset; validity is tracked by vld_q/count_q only.
    logic [29:0]      addr_q  [DEPTH];
    logic [31:0]      wdata_q [DEPTH];
    logic [3:0]       be_q    [DEPTH];

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [29:0]      ent_addr_d;
    logic [31:0]      ent_wdata_d;
    logic [3:0]       ent_be_d;
    logic             store_req, full, mem_we, push, pop, hit;
    logic             unused_bits;

    assign unused_bits = ^bus.loadadrM[1:0];

    always_comb begin
        ent_addr_d  = bus.aluoutM[31:2];
        ent_wdata_d = '0;
        ent_be_d    = '0;
        case (bus.memwriteM)
            2'b01: begin
                ent_be_d    = 4'b1111;
                ent_wdata_d = bus.writedataM;
            end
            2'b10: begin
                ent_be_d    = bus.aluoutM[1] ? 4'b1100 : 4'b0011;
                ent_wdata_d = {2{bus.writedataM[15:0]}};
            end
            2'b11: begin
                ent_be_d    = 4'b0001 << bus.aluoutM[1:0];
                ent_wdata_d = {4{bus.writedataM[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        store_req = bus.memwriteM != 2'b00;
        full      = count_q == FULL_CNT;
        mem_we    = count_q != '0;
        pop       = mem_we && bus.mem_ready;
        push      = store_req && (!full || pop);

        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // Clear before set: when full, push and pop hit the same slot.
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
        end
        if (push) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
    end

    // Entries being popped this cycle still count as overlapping.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == bus.loadadrM[31:2])) hit = 1'b1;
        end
    end

    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_we ? {addr_q[head_q], 2'b00} : '0;
    assign bus.mem_wdata = mem_we ? wdata_q[head_q] : '0;
    assign bus.mem_be    = mem_we ? be_q[head_q] : '0;
    assign bus.stall     = store_req && full && !pop;
    assign bus.hazard    = bus.memreadM && hit;
    assign bus.count     = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q]  <= ent_addr_d;
            wdata_q[tail_q] <= ent_wdata_d;
            be_q[tail_q]    <= ent_be_d;
        end
    end
endmodule
